// File: rtl/tinyml_axi_resp_router.sv
// Response-path router: a FIFO of granted port indices steers the in-order shared
// response stream back to its originating master port. Optional build macro:
// TINYML_RESP_ROUTER_ERR_EN (sticky orphan flag plus sinking of orphan beats).
module tinyml_axi_resp_router #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PW         = $clog2(PORTS),
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    input  logic [PW-1:0]               issue_port,
    output logic                        issue_ready,
    input  logic [DATA_WIDTH-1:0]       s_resp_data,
    input  logic                        s_resp_last,
    input  logic                        s_resp_valid,
    output logic                        s_resp_ready,
    output logic [PORTS*DATA_WIDTH-1:0] m_resp_data,
    output logic [PORTS-1:0]            m_resp_last,
    output logic [PORTS-1:0]            m_resp_valid,
    input  logic [PORTS-1:0]            m_resp_ready,
    output logic [CW-1:0]               outstanding,
    output logic                        orphan_err
);
    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // valid never depends on ready, and a held beat stays stable until accepted.
    localparam int AW = $clog2(DEPTH);

    logic [PW-1:0]         fifo_mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  out_valid;
    logic                  out_last;
    logic [DATA_WIDTH-1:0] out_data;
    logic [PW-1:0]         out_port;
    logic                  fifo_empty;
    logic                  route_ready;
    logic                  push;
    logic                  pop;
    logic                  accept;
    logic                  out_drain;

    assign fifo_empty  = (count == '0);
    assign issue_ready = (count != CW'(DEPTH));
    assign push        = issue_valid && issue_ready;
    assign out_drain   = out_valid && m_resp_ready[out_port];
    assign route_ready = !fifo_empty && (!out_valid || m_resp_ready[out_port]);
    assign accept      = s_resp_valid && route_ready;
    assign pop         = accept && s_resp_last;
    assign outstanding = count;

`ifdef TINYML_RESP_ROUTER_ERR_EN
    // Beats with no recorded owner are swallowed so the shared slave never wedges.
    assign s_resp_ready = route_ready || (fifo_empty && s_resp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            orphan_err <= 1'b0;
        end else if (s_resp_valid && fifo_empty) begin
            orphan_err <= 1'b1;
        end
    end
`else
    assign s_resp_ready = route_ready;
    assign orphan_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= issue_port;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Single output register; a new beat may load in the same cycle the old one drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_port  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_last  <= s_resp_last;
            out_data  <= s_resp_data;
            out_port  <= fifo_mem[rd_ptr];
        end else if (out_drain) begin
            out_valid <= 1'b0;
        end
    end

    always_comb begin
        m_resp_valid = '0;
        m_resp_data  = '0;
        for (int i = 0; i < PORTS; i++) begin
            m_resp_valid[i] = out_valid && (out_port == PW'(i));
            m_resp_data[i*DATA_WIDTH +: DATA_WIDTH] = out_data;
        end
    end

    assign m_resp_last = {PORTS{out_last}};

endmodule

// File: tb/tb_tinyml_axi_resp_router.sv
// Directed bench for tinyml_axi_resp_router: routing, ordering, backpressure,
// full FIFO, reset mid-burst and orphan handling.
module tb_tinyml_axi_resp_router;
    localparam int PORTS = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int PW    = 2;
    localparam int CW    = 4;
`ifdef TINYML_RESP_ROUTER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  issue_valid;
    logic [PW-1:0]         issue_port;
    logic                  issue_ready;
    logic [DW-1:0]         s_resp_data;
    logic                  s_resp_last;
    logic                  s_resp_valid;
    logic                  s_resp_ready;
    logic [PORTS*DW-1:0]   m_resp_data;
    logic [PORTS-1:0]      m_resp_last;
    logic [PORTS-1:0]      m_resp_valid;
    logic [PORTS-1:0]      m_resp_ready;
    logic [CW-1:0]         outstanding;
    logic                  orphan_err;

    int checks   = 0;
    int failures = 0;

    tinyml_axi_resp_router #(.PORTS(PORTS), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_port(issue_port), .issue_ready(issue_ready),
        .s_resp_data(s_resp_data), .s_resp_last(s_resp_last),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
        .m_resp_data(m_resp_data), .m_resp_last(m_resp_last),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
        .outstanding(outstanding), .orphan_err(orphan_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every port's payload slice must match since the register is broadcast.
    task automatic check_out(input string tag, input logic [PORTS-1:0] vld,
                             input logic [DW-1:0] data, input logic last);
        check_eq({tag, "_valid"}, 64'(m_resp_valid), 64'(vld));
        for (int i = 0; i < PORTS; i++)
            check_eq({tag, "_data"}, 64'(m_resp_data[i*DW +: DW]), 64'(data));
        check_eq({tag, "_last"}, 64'(m_resp_last), 64'({PORTS{last}}));
    endtask

    task automatic drive_beat(input logic [DW-1:0] data, input logic last);
        s_resp_valid = 1'b1;
        s_resp_data  = data;
        s_resp_last  = last;
    endtask

    logic [PW-1:0] burst_port [7];
    logic          burst_last [7];

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_port = '0;
        s_resp_valid = 1'b0; s_resp_data = '0; s_resp_last = 1'b0;
        m_resp_ready = '1;
        step(); step();
        rst = 1'b0;
        step();
        check_out("reset", 4'b0000, 32'h0, 1'b0);
        check_eq("reset_outstanding", 64'(outstanding), 64'd0);
        check_eq("reset_issue_ready", 64'(issue_ready), 64'd1);
        check_eq("reset_s_ready", 64'(s_resp_ready), 64'd0);
        check_eq("reset_orphan", 64'(orphan_err), 64'd0);

        // Single beat to port 2
        issue_valid = 1'b1; issue_port = 2'd2;
        step();
        issue_valid = 1'b0;
        check_eq("single_outstanding1", 64'(outstanding), 64'd1);
        drive_beat(32'hA5A5_0001, 1'b1);
        #1 check_eq("single_s_ready", 64'(s_resp_ready), 64'd1);
        step();
        s_resp_valid = 1'b0;
        check_out("single_out", 4'b0100, 32'hA5A5_0001, 1'b1);
        check_eq("single_outstanding0", 64'(outstanding), 64'd0);
        step();
        check_eq("single_drained", 64'(m_resp_valid), 64'd0);

        // Bursts of 4,1,2 beats to ports 3,0,1, streamed with no bubbles
        burst_port = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1, 2'd1};
        burst_last = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        issue_valid = 1'b1;
        issue_port = 2'd3; step();
        issue_port = 2'd0; step();
        issue_port = 2'd1; step();
        issue_valid = 1'b0;
        check_eq("burst_outstanding3", 64'(outstanding), 64'd3);
        for (int k = 0; k < 7; k++) begin
            drive_beat(32'h1000_0000 + 32'(k), burst_last[k]);
            #1 check_eq("burst_s_ready", 64'(s_resp_ready), 64'd1);
            step();
            check_out("burst_out", 4'(1 << burst_port[k]), 32'h1000_0000 + 32'(k), burst_last[k]);
        end
        s_resp_valid = 1'b0;
        check_eq("burst_outstanding0", 64'(outstanding), 64'd0);
        step();
        check_eq("burst_drained", 64'(m_resp_valid), 64'd0);

        // Backpressure on port 1 for five cycles in the middle of a 4-beat burst
        issue_valid = 1'b1; issue_port = 2'd1;
        step();
        issue_valid = 1'b0;
        drive_beat(32'hB000_0000, 1'b0);
        step();
        check_out("bp_beat0", 4'b0010, 32'hB000_0000, 1'b0);
        m_resp_ready = 4'b1101;
        drive_beat(32'hB000_0001, 1'b0);
        #1 check_eq("bp_stall_s_ready", 64'(s_resp_ready), 64'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            check_out("bp_hold", 4'b0010, 32'hB000_0000, 1'b0);
            check_eq("bp_hold_s_ready", 64'(s_resp_ready), 64'd0);
        end
        m_resp_ready = 4'b1111;
        #1 check_eq("bp_release_s_ready", 64'(s_resp_ready), 64'd1);
        for (int k = 1; k < 4; k++) begin
            drive_beat(32'hB000_0000 + 32'(k), (k == 3));
            step();
            check_out("bp_beat", 4'b0010, 32'hB000_0000 + 32'(k), (k == 3));
        end
        s_resp_valid = 1'b0;
        check_eq("bp_outstanding0", 64'(outstanding), 64'd0);
        step();
        check_eq("bp_drained", 64'(m_resp_valid), 64'd0);

        // Fill the tracking FIFO, then try a ninth issue and a push+pop at full
        issue_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            issue_port = PW'(i % PORTS);
            step();
        end
        issue_port = 2'd2;
        check_eq("full_outstanding8", 64'(outstanding), 64'd8);
        check_eq("full_issue_ready", 64'(issue_ready), 64'd0);
        step();
        check_eq("full_ninth_dropped", 64'(outstanding), 64'd8);
        drive_beat(32'hF000_0000, 1'b1);
        #1 check_eq("full_pushpop_s_ready", 64'(s_resp_ready), 64'd1);
        step();
        issue_valid = 1'b0;
        check_eq("full_pushpop_count7", 64'(outstanding), 64'd7);
        check_out("full_pop0", 4'b0001, 32'hF000_0000, 1'b1);
        for (int k = 1; k < DEPTH; k++) begin
            drive_beat(32'hF000_0000 + 32'(k), 1'b1);
            step();
            check_out("full_pop", 4'(1 << (k % PORTS)), 32'hF000_0000 + 32'(k), 1'b1);
        end
        s_resp_valid = 1'b0;
        check_eq("full_outstanding0", 64'(outstanding), 64'd0);
        step();

        // Reset during beat 2 of a 4-beat burst; remaining beats become orphans
        issue_valid = 1'b1; issue_port = 2'd2;
        step();
        issue_valid = 1'b0;
        drive_beat(32'hC000_0000, 1'b0);
        step();
        check_out("rst_beat0", 4'b0100, 32'hC000_0000, 1'b0);
        drive_beat(32'hC000_0001, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_out("rst_cleared", 4'b0000, 32'h0, 1'b0);
        check_eq("rst_outstanding", 64'(outstanding), 64'd0);
        check_eq("rst_issue_ready", 64'(issue_ready), 64'd1);
        drive_beat(32'hC000_0002, 1'b0);
        #1 check_eq("orphan_s_ready", 64'(s_resp_ready), 64'(ERR_EN));
        step();
        check_eq("orphan_no_valid", 64'(m_resp_valid), 64'd0);
        check_eq("orphan_err_set", 64'(orphan_err), 64'(ERR_EN));
        s_resp_valid = 1'b0;
        step();
        check_eq("orphan_no_valid2", 64'(m_resp_valid), 64'd0);
        check_eq("orphan_err_sticky", 64'(orphan_err), 64'(ERR_EN));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("orphan_err_cleared", 64'(orphan_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tinyml_axi_resp_router.md
Name: tinyml_axi_resp_router

Overview:
Return-path companion to the N:1 request arbiter. It records the granted port index for every transfer the arbiter issues downstream and steers the shared in-order response stream back to the originating port. One response burst is routed per issued transfer, terminated by the last beat. It sits between the shared slave's R/B channel and the PORTS master-side response channels.

Parameters:
PORTS, 4, number of master ports (>=2)
DATA_WIDTH, 32, response payload width
DEPTH, 8, max outstanding transfers; power of 2, >=2
(derived) PW = $clog2(PORTS), CW = $clog2(DEPTH+1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
issue_valid  in  1  transfer accepted downstream this cycle (arbiter grant handshake)
issue_port  in  PW  grant_encoded of that transfer
issue_ready  out  1  tracking FIFO can accept an entry
s_resp_data  in  DATA_WIDTH  shared response payload
s_resp_last  in  1  final beat of burst
s_resp_valid  in  1  shared response valid
s_resp_ready  out  1  shared response ready
m_resp_data  out  PORTS*DATA_WIDTH  per-port payload, port i at [i*DATA_WIDTH +: DATA_WIDTH]
m_resp_last  out  PORTS  per-port last
m_resp_valid  out  PORTS  per-port valid, at most one bit set
m_resp_ready  in  PORTS  per-port ready
outstanding  out  CW  entries in tracking FIFO
orphan_err  out  1  sticky orphan-response flag (see Optional Feature)

Behaviour:
- Reset: FIFO pointers/count 0, output stage empty; m_resp_valid=0, m_resp_last=0, m_resp_data=0, outstanding=0, orphan_err=0, s_resp_ready=0; issue_ready=1 from the first cycle after reset.
- Tracking FIFO: DEPTH x PW, registered pointers plus count. Push on issue_valid && issue_ready. issue_ready = (count != DEPTH), computed from registered count only; no push when full even if a pop occurs in the same cycle. issue_valid while !issue_ready is dropped.
- Head port = FIFO head entry, valid only when count != 0.
- Output stage: single register (valid, data, last, port). Latency from s_resp beat to m_resp_valid is 1 cycle.
- s_resp_ready = (count != 0) && (!out_valid || m_resp_ready[out_port]). Full throughput: one beat per cycle while the target stays ready.
- Beat accept (s_resp_valid && s_resp_ready): load output register with data, last, head port. If s_resp_last, pop FIFO the same cycle. The next beat routes to the new head.
- Output drains when m_resp_ready[out_port]; the stage clears unless reloaded in the same cycle.
- m_resp_valid[i] = out_valid && (out_port==i). m_resp_data/m_resp_last broadcast the register to all ports; only valid is decoded.
- Simultaneous push and pop: count unchanged, both pointers advance. A push into an empty FIFO cannot be consumed in the same cycle (s_resp_ready still 0).
- Pointer wrap: modulo DEPTH, natural binary wrap.
- outstanding = count, registered.
- Reset mid-burst: all state cleared immediately. Beats still arriving afterwards are orphans.
- Orphan: s_resp_valid while count==0. Beat is not accepted (s_resp_ready=0) and stalls upstream.

Optional Feature:
TINYML_RESP_ROUTER_ERR_EN
- Defined: orphan_err sets on any cycle with s_resp_valid && count==0 and holds until rst. Orphan beats are then sunk (s_resp_ready=1, beat discarded, no output), so upstream never deadlocks.
- Undefined: orphan_err tied 0, orphan beats stall as described above. No extra logic.

Test Plan:
- Single beat: issue port 2, then 1 beat data=0xA5A5_0001 last=1 -> m_resp_valid=4'b0100 one cycle later, data=0xA5A5_0001; outstanding 1->0.
- Burst plus ordering: issue ports 3,0,1; send bursts of 4,1,2 beats (last on beats 4,5,7) -> beats appear in order on ports 3(x4), 0(x1), 1(x2); no bubbles with all ready=1; 7 consecutive valid cycles.
- Backpressure: m_resp_ready[1]=0 for 5 cycles mid-burst -> s_resp_ready=0 during stall, held beat unchanged, no beat lost or duplicated after release.
- Full FIFO: 8 issues without responses -> issue_ready=0, outstanding=8; 9th issue_valid ignored; push+pop in the same cycle at count=8 -> push rejected, count 7.
- Reset mid-burst: rst during beat 2 of 4 -> next cycle all m_resp_valid=0, outstanding=0, issue_ready=1; remaining beats not accepted (macro off).
- Orphan with TINYML_RESP_ROUTER_ERR_EN: s_resp_valid with empty FIFO -> beat sunk, orphan_err=1 until rst, no m_resp_valid asserted.
